// File: rtl/cic_capture_ctrl_if.sv
// Output stream of the CIC capture sequencer: FIFO head word offered on a
// valid/ready handshake. The sequencer drives the master side and the
// readout logic sits on the slave side.
interface cic_capture_ctrl_if #(
  parameter int DATA_W = 25
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/cic_capture_ctrl.sv
// Sequencer for the sigma-delta / CIC3 decimator datapath.
// Generates the decimation strobe for the comb stage, throws away the CIC
// fill-up words after every start, and queues the valid decimated words in
// a small FIFO that is drained over a valid/ready stream. A sticky flag
// records any word dropped because the FIFO was full.
module cic_capture_ctrl #(
  parameter int DATA_W   = 25,
  parameter int CNT_W    = 8,
  parameter int CIC_LAT  = 1,
  parameter int SETTLE_N = 3,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [CNT_W-1:0]         dec_ratio_m1,
  input  logic [DATA_W-1:0]        cic_data,
  output logic                     dec_strobe,
  cic_capture_ctrl_if.master       stream,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     settling,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = (SETTLE_N < 1) ? 1 : $clog2(SETTLE_N + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN
  } state_t;

  state_t            state;
  state_t            state_next;

  logic              running;
  logic              start;
  logic              stop;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  ratio_q;

  logic [CIC_LAT-1:0] cap_pipe;
  logic [CIC_LAT-1:0] pipe_in;
  logic               pipe_clr;
  logic               cap_en;

  logic [SW-1:0]     discard_cnt;
  logic              cap_discard;
  logic              push;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [LW-1:0]     wr_ptr;
  logic [LW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic [LW-1:0]     level_after_pop;
  logic [LW-1:0]     rd_next;
  logic              full;
  logic              pop;
  logic              push_ok;
  logic              ov_set;
  logic [DATA_W-1:0] head_reg;
  logic [DATA_W-1:0] head_next;

  // Control qualifiers shared by the FSM and the datapath.
  assign running  = (state != ST_IDLE);
  assign start    = (state == ST_IDLE) && enable;
  assign stop     = running && !enable;
  assign settling = (state == ST_SETTLE);

  // Strobe fires on the terminal count, so the period is ratio_q + 1.
  assign dec_strobe = running && (cnt == ratio_q);

  // ------------------------------------------------------------------
  // Sequencer FSM
  // ------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state: leave SETTLE on the cycle of the last discard so the very
  // next capture already goes to the FIFO; enable low always wins.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!enable) state_next = ST_IDLE;
        else if (cap_en && (discard_cnt == SW'(SETTLE_N - 1))) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Decimation counter
  // ------------------------------------------------------------------

  // Ratio is latched only at start; a zero ratio is bumped to 1 so the
  // strobe can never be stuck high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ratio_q <= '0;
    else if (start) ratio_q <= (dec_ratio_m1 == '0) ? CNT_W'(1) : dec_ratio_m1;
  end

  // Free-running counter while active, held at zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     cnt <= '0;
    else if (!running || stop)     cnt <= '0;
    else if (cnt == ratio_q)       cnt <= '0;
    else                           cnt <= cnt + CNT_W'(1);
  end

  // ------------------------------------------------------------------
  // Capture pipeline: strobe delayed by the CIC output latency
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < CIC_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_first
        assign pipe_in[gi] = dec_strobe;
      end else begin : g_rest
        assign pipe_in[gi] = cap_pipe[gi - 1];
      end
    end
  endgenerate

  // Stopping (or idling) wipes strobes still in flight; a capture that is
  // already at the end of the chain this cycle is still consumed below.
  assign pipe_clr = !running || stop;

  // Strobe delay line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         cap_pipe <= '0;
    else if (pipe_clr) cap_pipe <= '0;
    else               cap_pipe <= pipe_in;
  end

  assign cap_en      = cap_pipe[CIC_LAT - 1];
  assign cap_discard = cap_en && (state == ST_SETTLE);
  assign push        = cap_en && (state == ST_RUN);

  // Number of settling words thrown away since the last start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            discard_cnt <= '0;
    else if (start)       discard_cnt <= '0;
    else if (cap_discard) discard_cnt <= discard_cnt + SW'(1);
  end

  // ------------------------------------------------------------------
  // Capture FIFO
  // ------------------------------------------------------------------
  assign level           = wr_ptr - rd_ptr;
  assign full            = (level == LW'(DEPTH));
  assign stream.out_valid = (level != '0);
  assign pop             = stream.out_valid && stream.out_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push_ok         = push && (!full || pop);
  assign ov_set          = push && full && !pop;
  assign level_after_pop = level - LW'(pop);
  assign rd_next         = rd_ptr + LW'(pop);
  assign fifo_level      = level;
  assign stream.out_data = head_reg;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + LW'(push_ok);
      rd_ptr <= rd_next;
    end
  end

  // Storage array, no reset needed: only slots behind the write pointer are read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= cic_data;
  end

  // Head word after this cycle: the incoming word if the FIFO ends up
  // holding only it, otherwise the entry at the advanced read pointer.
  always_comb begin
    head_next = '0;
    if (start) begin
      head_next = '0;
    end else if (level_after_pop == '0) begin
      head_next = push_ok ? cic_data : '0;
    end else begin
      head_next = mem[rd_next[AW-1:0]];
    end
  end

  // Registered head so out_data never sees the array read path directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) head_reg <= '0;
    else       head_reg <= head_next;
  end

  // Sticky overflow; a fresh drop beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             overflow <= 1'b0;
    else if (ov_set)       overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_cic_capture_ctrl.sv
// Bench for cic_capture_ctrl: directed phases with random data, ready and
// control, every cycle compared against a queue-based reference model that
// derives strobe timing from elapsed cycles modulo the decimation period.
module tb_cic_capture_ctrl;
  localparam int DATA_W   = 25;
  localparam int CNT_W    = 8;
  localparam int CIC_LAT  = 1;
  localparam int SETTLE_N = 3;
  localparam int DEPTH    = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [CNT_W-1:0]  dec_ratio_m1;
  logic [DATA_W-1:0] cic_data;
  logic              dec_strobe;
  logic [2:0]        fifo_level;
  logic              settling;
  logic              overflow;
  logic              overflow_clr;

  cic_capture_ctrl_if #(.DATA_W(DATA_W)) stream_if ();

  cic_capture_ctrl #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .CIC_LAT(CIC_LAT),
    .SETTLE_N(SETTLE_N), .DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .dec_ratio_m1 (dec_ratio_m1),
    .cic_data     (cic_data),
    .dec_strobe   (dec_strobe),
    .stream       (stream_if),
    .fifo_level   (fifo_level),
    .settling     (settling),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit seq_mode = 1'b0;

  // Reference model state.
  bit                m_active;
  int                m_t;       // cycles since entering the active phase
  int                m_r;       // latched ratio (period m_r + 1)
  int                m_left;    // settling words still to discard
  int                m_words;   // post-settle captures since start
  bit                m_ov;
  logic [DATA_W-1:0] m_q[$];
  int                m_pend[$]; // cycle numbers (m_t) at which captures land

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_strobe();
    return m_active && (((m_t + 1) % (m_r + 1)) == 0);
  endfunction

  function automatic bit m_cap_now();
    return m_active && (m_pend.size() != 0) && (m_pend[0] == m_t);
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_t = 0; m_r = 0; m_left = 0; m_words = 0; m_ov = 1'b0;
    m_q.delete(); m_pend.delete();
  endtask

  task automatic check_outputs();
    logic [DATA_W-1:0] exp_head;
    exp_head = (m_q.size() != 0) ? m_q[0] : '0;
    check("dec_strobe", 32'(dec_strobe), 32'(m_strobe()));
    check("out_valid",  32'(stream_if.out_valid), 32'(m_q.size() != 0));
    check("out_data",   32'(stream_if.out_data), 32'(exp_head));
    check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check("settling",   32'(settling), 32'(m_active && (m_left > 0)));
    check("overflow",   32'(overflow), 32'(m_ov));
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    bit pop, cap, push, stb, newov;
    pop = (m_q.size() != 0) && stream_if.out_ready;
    if (!m_active) begin
      if (pop) void'(m_q.pop_front());
      if (overflow_clr) m_ov = 1'b0;
      if (enable) begin
        m_active = 1'b1; m_t = 0; m_words = 0;
        m_r = (dec_ratio_m1 == 0) ? 1 : int'(dec_ratio_m1);
        m_left = SETTLE_N;
        m_q.delete(); m_pend.delete();
      end
    end else begin
      stb = m_strobe();
      cap = m_cap_now();
      if (cap) void'(m_pend.pop_front());
      push = 1'b0;
      if (cap) begin
        if (m_left > 0) m_left--;
        else begin push = 1'b1; m_words++; end
      end
      newov = push && (m_q.size() == DEPTH) && !pop;
      if (pop) void'(m_q.pop_front());
      if (push && !newov) m_q.push_back(cic_data);
      if (overflow_clr) m_ov = 1'b0;
      if (newov) m_ov = 1'b1;
      if (stb) m_pend.push_back(m_t + CIC_LAT);
      if (!enable) begin m_active = 1'b0; m_pend.delete(); end
      else m_t++;
    end
  endtask

  // One clock: choose data, compare, step model, move to next falling edge.
  task automatic cyc();
    if (seq_mode) cic_data = DATA_W'(m_words + 1);
    else          cic_data = DATA_W'($urandom);
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Cycles until the next observed strobe, capped at a 64-cycle window.
  task automatic measure(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      n++;
      if (dec_strobe) break;
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; dec_ratio_m1 = '0; cic_data = '0;
    overflow_clr = 1'b0; stream_if.out_ready = 1'b0;
    model_reset();
    #1;
    check("rst_strobe", 32'(dec_strobe), 32'd0);
    check("rst_level",  32'(fifo_level), 32'd0);
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    // Strobe period and settling, ratio 10.
    dec_ratio_m1 = 8'd9; stream_if.out_ready = 1'b1; enable = 1'b1;
    measure(n);
    check("first_strobe_delay", 32'(n), 32'd10);
    measure(n);
    check("strobe_period_10", 32'(n), 32'd10);
    for (int i = 0; i < 200 && m_words < 1; i++) cyc();
    check("settled", 32'(settling), 32'd0);
    repeat (40) cyc();

    // Ratio clamp and mid-run ratio change.
    enable = 1'b0; cyc(); cyc();
    dec_ratio_m1 = 8'd0; enable = 1'b1;
    measure(n);
    measure(n);
    check("clamp_period", 32'(n), 32'd2);
    dec_ratio_m1 = 8'd4;
    repeat (10) cyc();
    measure(n);
    check("period_after_change", 32'(n), 32'd2);

    // Overflow with sequential words, then clear and drain.
    enable = 1'b0; cyc();
    stream_if.out_ready = 1'b0; seq_mode = 1'b1; dec_ratio_m1 = 8'd3; enable = 1'b1;
    for (int i = 0; i < 400 && (m_words < 5 || !m_active); i++) cyc();
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_head",  32'(stream_if.out_data), 32'd1);
    enable = 1'b0; overflow_clr = 1'b1; stream_if.out_ready = 1'b1;
    cyc();
    overflow_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    for (int k = 2; k <= 4; k++) begin
      check("drain_order", 32'(stream_if.out_data), 32'(k));
      cyc();
    end
    check("drained", 32'(fifo_level), 32'd0);
    seq_mode = 1'b0;

    // Full FIFO with push and pop in the same cycle.
    stream_if.out_ready = 1'b0; dec_ratio_m1 = 8'd1; enable = 1'b1;
    for (int i = 0; i < 200 && m_q.size() < DEPTH; i++) cyc();
    for (int i = 0; i < 100 && !m_cap_now(); i++) cyc();
    stream_if.out_ready = 1'b1;
    cyc();
    stream_if.out_ready = 1'b0;
    check("full_pushpop_level", 32'(fifo_level), 32'd4);
    check("full_pushpop_ovf",   32'(overflow), 32'd0);
    repeat (3) cyc();

    // Disable with three words queued, drain one, re-enable flushes.
    enable = 1'b0; stream_if.out_ready = 1'b1;
    for (int i = 0; i < 20 && m_q.size() != 0; i++) cyc();
    stream_if.out_ready = 1'b0; dec_ratio_m1 = 8'd2; enable = 1'b1;
    for (int i = 0; i < 200 && m_q.size() < 3; i++) cyc();
    enable = 1'b0;
    cyc();
    check("stopped_strobe", 32'(dec_strobe), 32'd0);
    repeat (10) cyc();
    check("held_level", 32'(fifo_level), 32'd3);
    stream_if.out_ready = 1'b1; cyc(); stream_if.out_ready = 1'b0;
    enable = 1'b1;
    cyc();
    check("flush_on_start", 32'(fifo_level), 32'd0);

    // Asynchronous reset mid-run with overflow set and words queued.
    dec_ratio_m1 = 8'd1;
    for (int i = 0; i < 200 && !m_ov; i++) cyc();
    stream_if.out_ready = 1'b1;
    for (int i = 0; i < 50 && m_q.size() > 2; i++) cyc();
    reset = 1'b1;
    #1;
    check("arst_strobe",   32'(dec_strobe), 32'd0);
    check("arst_valid",    32'(stream_if.out_valid), 32'd0);
    check("arst_data",     32'(stream_if.out_data), 32'd0);
    check("arst_level",    32'(fifo_level), 32'd0);
    check("arst_settling", 32'(settling), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc();
    check("restart_settling", 32'(settling), 32'd1);
    repeat (30) cyc();

    // Random soak.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 7) == 0) dec_ratio_m1 = CNT_W'($urandom_range(0, 5));
      stream_if.out_ready = ($urandom_range(0, 2) != 0) && ((i / 200) % 2 == 0);
      overflow_clr = ($urandom_range(0, 9) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cic_capture_ctrl.md
Name: cic_capture_ctrl

Overview:
Sequencer for the sigma-delta modulator / CIC3 decimator datapath. It generates the decimation strobe that clocks the CIC comb stage and discards the CIC settling outputs after each start. It captures valid decimated 25-bit words into a small FIFO and presents them downstream on a valid/ready handshake, with a sticky overflow flag. It sits between cic3_echip65 and the readout/digital-monitor logic.

Parameters:
DATA_W, 25, width of the CIC output word
CNT_W, 8, width of the decimation counter and ratio input
CIC_LAT, 1, cycles from dec_strobe until cic_data holds the new decimated word (1..4)
SETTLE_N, 3, number of decimated words discarded after start (CIC3 fill)
DEPTH, 4, FIFO depth (power of 2)

Ports:
clk  in  1  system clock; all logic is rising-edge
reset  in  1  asynchronous active-high reset
enable  in  1  run request, level-sensitive
dec_ratio_m1  in  CNT_W  decimation ratio minus one; sampled on start
cic_data  in  DATA_W  CIC decimated output word
dec_strobe  out  1  one-cycle pulse to CIC comb/decimate stage
out_data  out  DATA_W  FIFO head word
out_valid  out  1  FIFO not empty
out_ready  in  1  downstream accept
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
settling  out  1  high while in SETTLE
overflow  out  1  sticky: a word was dropped because the FIFO was full
overflow_clr  in  1  clears overflow

Behaviour:
- Reset (async, while high): state IDLE, counter 0, latched ratio 0, capture pipeline cleared, FIFO empty. Outputs: dec_strobe=0, out_valid=0, out_data=0, fifo_level=0, settling=0, overflow=0.
- States: IDLE, SETTLE, RUN.
- IDLE -> SETTLE when enable=1.
  - On that edge: latch ratio_q = max(dec_ratio_m1, 1), so the minimum ratio is 2.
  - Also on that edge: counter=0, discard count=0, FIFO flushed (level 0). Overflow is not touched.
- SETTLE -> RUN after SETTLE_N captures have been discarded.
- SETTLE or RUN -> IDLE the cycle after enable=0.
  - Counter is held at 0 and in-flight captures are cancelled.
  - FIFO contents are kept and remain drainable.
- Decimation counter, in SETTLE and RUN:
  - Increments each cycle and wraps to 0 after reaching ratio_q.
  - dec_strobe=1 for exactly the cycle in which counter==ratio_q, giving period ratio_q+1.
  - First strobe comes ratio_q+1 cycles after entering SETTLE.
  - dec_ratio_m1 changes while running are ignored until the next start.
- Capture:
  - A CIC_LAT-deep shift of dec_strobe produces cap_en.
  - When cap_en=1, cic_data is sampled that cycle.
  - In SETTLE the sample is discarded (count++). In RUN it is pushed to the FIFO.
  - The SETTLE->RUN transition happens on the cycle of the SETTLE_N-th discard, so the next capture is pushed.
- FIFO: circular buffer with read/write pointers carrying an extra wrap bit.
  - out_valid = (level != 0); out_data = head word, registered, 0 when empty.
  - Pop when out_valid && out_ready.
  - out_ready while empty has no effect; no underflow.
- Simultaneous events:
  - Push and pop with the FIFO full: both occur, level is unchanged, no overflow.
  - Push and pop with the FIFO empty: the push is accepted and there is no pop; data is visible the next cycle (no bypass).
  - Push with the FIFO full and no pop: the word is dropped and overflow is set to 1.
  - overflow_clr and a new overflow in the same cycle: set wins.
  - enable falls on the same cycle as cap_en: that capture is still processed; later ones are cancelled.
  - enable re-asserted while the FIFO is non-empty: the FIFO is flushed and the unread data is lost by design.
- Widths: level saturates at DEPTH by construction. The counter compare is unsigned on CNT_W bits.

Test Plan:
- Reset mid-run:
  - Stimulus: assert reset while in RUN with 2 words in the FIFO and overflow=1.
  - Required: the same cycle, all outputs are 0, state is IDLE, fifo_level=0. With enable held high, SETTLE restarts after reset releases.
- Strobe period and settling:
  - Stimulus: dec_ratio_m1=9, enable=1, CIC_LAT=1, ready=1.
  - Required: first dec_strobe 10 cycles after start, then every 10 cycles. settling=1 until the 3rd discard. The 4th strobe's cic_data appears on out_valid 2 cycles after that strobe (capture then FIFO register).
- Ratio clamp:
  - Stimulus: dec_ratio_m1=0.
  - Required: strobe period is 2 cycles. Changing dec_ratio_m1 to 4 mid-RUN leaves the period at 2 until re-enable.
- Overflow and recovery:
  - Stimulus: out_ready=0, run until 5 post-settle captures, with cic_data = 0x0000001..0x0000005.
  - Required: fifo_level=4, overflow=1, and the FIFO holds words 1..4.
  - Then pulse overflow_clr with ready=1: overflow=0, and words drain in order 1,2,3,4.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, out_ready=1 on the capture cycle.
  - Required: level stays 4, overflow stays 0, order is preserved.
- Disable and drain:
  - Stimulus: drop enable with 3 words queued.
  - Required: dec_strobe stops the next cycle, the 3 words remain drainable, and no further pushes occur. Re-enabling flushes the FIFO to level 0.
